ch0re_ifetch: RTL
=================

CH0RE_IFETCH -- requirements
Module: ch0re_ifetch

Interface
REQ-001 Parameter RESET_PC, 64'h0, address of the first fetch after reset.
REQ-002 Parameter DEPTH, 2, instruction buffer entries and maximum in-flight plus buffered fetches (power of two, at least 2).
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset; synchronous and active-low.
REQ-005 o_imem_req  out  1  instruction memory request valid.
REQ-006 o_imem_addr  out  64  fetch address, word aligned.
REQ-007 i_imem_gnt  in  1  request accepted this cycle.
REQ-008 i_imem_rvalid  in  1  response valid; responses return in order, at least 1 cycle after grant.
REQ-009 i_imem_rdata  in  32  response instruction word.
REQ-010 i_redirect  in  1  taken branch, jump or exception; flush and refetch.
REQ-011 i_redirect_pc  in  64  redirect target; bits [1:0] ignored and treated as 0.
REQ-012 i_stall  in  1  decode stage cannot accept an instruction this cycle.
REQ-013 o_valid  out  1  o_instr and o_pc hold a valid instruction.
REQ-014 o_instr  out  32  instruction to the decoder.
REQ-015 o_pc  out  64  PC of o_instr.

Function
REQ-016 Fetch PC register fpc; a request is accepted when o_imem_req & i_imem_gnt, and then fpc <= fpc + 4.
REQ-017 o_imem_addr = {fpc[63:2], 2'b00}; o_imem_req and o_imem_addr hold stable until granted.
REQ-018 Counters: out_cnt counts granted, unreturned requests; occ counts buffer entries.
- o_imem_req = (state == FETCH) & (out_cnt + occ < DEPTH).
REQ-019 FIFO of DEPTH entries holding {pc, instr}, with a pc side-queue recording the address of each granted request.
- A non-discarded rvalid writes {queued pc, rdata}.
REQ-020 o_valid = (occ != 0); o_instr and o_pc come from the FIFO head.
- When o_valid = 0: o_instr = 32'h0000_0013 (NOP) and o_pc = 0.
REQ-021 The head is popped when o_valid & !i_stall.
- Push and pop in the same cycle leave occ unchanged.
- Pointers wrap modulo DEPTH.
REQ-022 The FIFO never overflows by construction (REQ-018); a push while full is an assertion failure.
REQ-023 FSM states FETCH and DRAIN.
REQ-024 i_redirect in any state:
- the FIFO is flushed (occ <= 0) and fpc <= i_redirect_pc;
- discard_cnt <= out_cnt + (o_imem_req & i_imem_gnt) - i_imem_rvalid;
- next state is DRAIN if that value is nonzero, else FETCH.
REQ-025 A response arriving in the redirect cycle is dropped.
REQ-026 A grant in the redirect cycle counts as stale.
- i_stall has no effect on the flush.
REQ-027 In DRAIN there are no requests, and each rvalid decrements discard_cnt without a push.
- At zero, the next state is FETCH and requests resume at the next cycle.
REQ-028 A new redirect during DRAIN reapplies REQ-024 with discard_cnt recomputed, and the latest target wins.
REQ-029 Latency: redirect in cycle N with nothing in flight gives o_imem_req in cycle N+1.
- The response arriving in cycle M gives o_valid in cycle M+1 (the FIFO is registered; no bypass).

Reset
REQ-030 While rst_n = 0 at a clock edge:
- fpc <= RESET_PC; occ, out_cnt, discard_cnt and pointers <= 0; state <= FETCH.
- o_imem_req = 0, o_valid = 0, o_instr = NOP, o_pc = 0.
REQ-031 The first request is asserted in the cycle after rst_n rises.
- A reset mid-operation discards all in-flight responses by clearing the counters.
- The memory side must also be reset.

Structure
REQ-032 ifetch_state_e (FETCH, DRAIN) and the NOP constant belong in the shared ch0re_types.sv package.
REQ-033 Sub-module ch0re_ifetch_fifo, a parameterised synchronous FIFO with count output, holds the {pc, instr} buffer.

Verification
REQ-034 Reset, gnt = 1, 1-cycle rvalid returning 32'h00500093 and 32'h00A00113.
- o_pc = 0 then 4, o_instr matches in order, back-to-back o_valid.
REQ-035 i_stall held for 5 cycles with gnt = 1.
- o_imem_req drops once out_cnt + occ = 2, the head stays at pc 0, and no instruction is lost after release.
REQ-036 Redirect to 64'h100 with 2 responses outstanding.
- Those 2 responses are dropped, state is DRAIN for 2 rvalids, then a request to 64'h100 follows and o_pc = 64'h100.
REQ-037 Redirect coinciding with a grant and an rvalid.
- The rvalid is dropped, discard_cnt = out_cnt, and no stale instruction appears on o_valid.
REQ-038 i_redirect_pc = 64'h203 gives o_imem_addr = 64'h200.
- rst_n low for 1 cycle mid-stream clears o_valid and restarts at RESET_PC.

Source files
------------

// File: rtl/ch0re_types.sv
// ch0re shared types
// fetch FSM states, NOP encoding, fetch buffer entry
package ch0re_types;

  typedef enum logic {
    FETCH,
    DRAIN
  } ifetch_state_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } ifetch_entry_t;

endpackage

// File: rtl/ch0re_ifetch_fifo.sv
// ch0re fetch: small synchronous FIFO
// registered storage with occupancy count and flush
module ch0re_ifetch_fifo #(
  parameter int W     = 96,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [W-1:0]           wdata,
  input  logic                   pop,
  output logic [W-1:0]           rdata,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          pop_ok;
  logic          full;

  assign full   = count == CW'(DEPTH);
  assign pop_ok = pop & (count != '0);
  assign rdata  = mem[rptr];

  // storage write; contents need no reset
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  // pointers wrap naturally, count tracks entries
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push)   wptr <= wptr + AW'(1);
      if (pop_ok) rptr <= rptr + AW'(1);
      count <= count + CW'(push) - CW'(pop_ok);
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(push && !flush && full)
  );

endmodule

// File: rtl/ch0re_ifetch.sv
// ch0re instruction fetch stage
// credit-limited requests, in-order buffer, redirect drain
module ch0re_ifetch
  import ch0re_types::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        o_imem_req,
  output logic [63:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_redirect,
  input  logic [63:0] i_redirect_pc,
  input  logic        i_stall,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [63:0] o_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  ifetch_state_e state_q, state_d;
  logic [63:0]   fpc_q, fpc_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] disc_q, disc_d;
  logic [CW-1:0] occ;
  logic [CW-1:0] pcq_cnt;
  logic [CW:0]   load;
  logic [63:0]   rsp_pc;
  logic          in_fetch;
  logic          fire;
  logic          push;
  logic          pop;
  ifetch_entry_t wentry;
  ifetch_entry_t head;

  assign in_fetch    = state_q == FETCH;
  assign load        = {1'b0, out_q} + {1'b0, occ};
  assign o_imem_req  = rst_n & in_fetch & (load < (CW+1)'(DEPTH));
  assign o_imem_addr = fpc_q & ~64'h3;
  assign fire        = o_imem_req & i_imem_gnt;

  assign push   = i_imem_rvalid & in_fetch & ~i_redirect
                & (pcq_cnt != '0);
  assign pop    = o_valid & ~i_stall & ~i_redirect;
  assign wentry = '{pc: rsp_pc, instr: i_imem_rdata};

  assign o_valid = occ != '0;
  assign o_instr = o_valid ? head.instr : NOP;
  assign o_pc    = o_valid ? head.pc : 64'h0;

  ch0re_ifetch_fifo #(
    .W     (64),
    .DEPTH (DEPTH)
  ) u_pcq (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (i_redirect),
    .push  (fire & ~i_redirect),
    .wdata (o_imem_addr),
    .pop   (push),
    .rdata (rsp_pc),
    .count (pcq_cnt)
  );

  ch0re_ifetch_fifo #(
    .W     ($bits(ifetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (i_redirect),
    .push  (push),
    .wdata (wentry),
    .pop   (pop),
    .rdata (head),
    .count (occ)
  );

  // next fetch pc, outstanding count, drain control
  always_comb begin
    state_d = state_q;
    fpc_d   = fpc_q;
    disc_d  = disc_q;
    out_d   = out_q + CW'(fire) - CW'(i_imem_rvalid);
    if (fire) fpc_d = fpc_q + 64'd4;
    unique case (state_q)
      FETCH: ;
      DRAIN: begin
        if (i_imem_rvalid) begin
          disc_d = disc_q - CW'(1);
          if (disc_q == CW'(1)) state_d = FETCH;
        end
      end
    endcase
    if (i_redirect) begin
      fpc_d   = i_redirect_pc & ~64'h3;
      disc_d  = out_d;
      state_d = (out_d != '0) ? DRAIN : FETCH;
    end
  end

  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FETCH;
      fpc_q   <= RESET_PC;
      out_q   <= '0;
      disc_q  <= '0;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      out_q   <= out_d;
      disc_q  <= disc_d;
    end
  end

endmodule
